// File: rtl/crc_err_inj_ctrl_pkg.sv
// Purpose : shared types and sizing helpers for the CRC error-injection controller.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: mode/state enums, LFSR feedback polynomial, flit-width and burst-position helpers.
package err_inj_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_RANDOM   = 2'd2,
        MODE_SINGLE   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FIRE  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Width of the concatenated {checksum, data} vector
    function automatic int calc_w(input int data_w, input int crc_w);
        return data_w + crc_w;
    endfunction

    // Number of legal burst start positions (0 .. W-BURST_LEN)
    function automatic int calc_pos_range(input int data_w, input int crc_w, input int burst_len);
        return data_w + crc_w - burst_len + 1;
    endfunction

endpackage

// File: rtl/crc_err_inj_ctrl_lfsr.sv
// Purpose : 32-bit Galois LFSR that steps once per asserted advance.
// Latency : new value visible the cycle after adv.
// Backpressure: none; the caller gates adv with its own handshake.
// Ports   : clk, rst (async, active-high), adv (step enable), lfsr (current state).
module err_inj_lfsr
    import err_inj_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [31:0] lfsr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (adv) begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/crc_err_inj_ctrl.sv
// Purpose : selects flits for CRC error injection and flips a bounded burst in {checksum, data}.
// Latency : 1 cycle from input acceptance to valid_o (single output register).
// Backpressure: ready_o = !valid_o || ready_i; the held flit stays stable while stalled.
// Ports   : cfg_* (latched on leaving IDLE), valid_i/ready_o/data_i/checksum_i in,
//           valid_o/ready_i/data_o/checksum_o/corrupted_o out, busy_o, inj_cnt_o/flit_cnt_o stats.
// Build   : define ERR_INJ_STATS_EN for live statistics counters; otherwise the stats read 0.
module crc_err_inj_ctrl
    import err_inj_pkg::*;
#(
    parameter int          DATA_WIDTH = 512,
    parameter int          CRC_WIDTH  = 32,
    parameter int          BURST_LEN  = 32,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_en,
    input  logic [1:0]            cfg_mode,
    input  logic [15:0]           cfg_period,
    input  logic [9:0]            cfg_start_bit,
    input  logic [BURST_LEN-1:0]  cfg_mask,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CRC_WIDTH-1:0]  checksum_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CRC_WIDTH-1:0]  checksum_o,
    output logic                  corrupted_o,
    output logic                  busy_o,
    output logic [31:0]           inj_cnt_o,
    output logic [31:0]           flit_cnt_o
);

    localparam int          W           = calc_w(DATA_WIDTH, CRC_WIDTH);
    localparam int          POS_RANGE   = calc_pos_range(DATA_WIDTH, CRC_WIDTH, BURST_LEN);
    localparam logic [31:0] POS_RANGE_L = 32'(POS_RANGE);
    localparam logic [9:0]  POS_MAX_L   = 10'(POS_RANGE - 1);

    state_e                 state_q, state_d;
    mode_e                  mode_q;
    logic [15:0]            period_q;
    logic [9:0]             start_q;
    logic [BURST_LEN-1:0]   mask_q;
    logic [15:0]            cnt_q, cnt_d;
    logic [31:0]            lfsr;
    logic                   acc;
    logic                   go;
    logic                   inject;
    logic                   lfsr_adv;
    logic [9:0]             start_sel;
    logic [BURST_LEN-1:0]   mask_sel;
    logic [W-1:0]           flip;
    logic [W-1:0]           vec_out;

    assign ready_o = !valid_o || ready_i;
    assign acc     = valid_i && ready_o;
    assign go      = cfg_en && (mode_e'(cfg_mode) != MODE_OFF);
    assign busy_o  = (state_q != ST_IDLE);

    // Random mode draws a fresh decision and burst from the LFSR on every accepted flit
    assign lfsr_adv = acc && (state_q == ST_COUNT) && (mode_q == MODE_RANDOM);

    err_inj_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (lfsr_adv),
        .lfsr (lfsr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inject  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                end
            end
            ST_COUNT: begin
                if (acc) begin
                    if (mode_q == MODE_RANDOM) begin
                        inject = lfsr[31];
                    end else if (period_q == 16'd1) begin
                        // A period of one never needs FIRE: every flit is the Nth flit
                        inject = 1'b1;
                        if (mode_q == MODE_SINGLE) state_d = ST_DONE;
                    end else if (cnt_q + 16'd1 == period_q - 16'd1) begin
                        state_d = ST_FIRE;
                        cnt_d   = cnt_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_FIRE: begin
                if (acc) begin
                    inject  = 1'b1;
                    cnt_d   = '0;
                    state_d = (mode_q == MODE_SINGLE) ? ST_DONE : ST_COUNT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!cfg_en) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mode_q   <= MODE_OFF;
            period_q <= 16'd1;
            start_q  <= '0;
            mask_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Configuration is only sampled on the way out of IDLE
            if (state_q == ST_IDLE && go) begin
                mode_q   <= mode_e'(cfg_mode);
                period_q <= (cfg_period == 16'd0) ? 16'd1 : cfg_period;
                start_q  <= (cfg_start_bit > POS_MAX_L) ? POS_MAX_L : cfg_start_bit;
                mask_q   <= cfg_mask;
            end
        end
    end

    // Burst selection: LFSR-derived in random mode, latched config otherwise
    always_comb begin
        start_sel = start_q;
        mask_sel  = mask_q;
        if (mode_q == MODE_RANDOM) begin
            start_sel = 10'(lfsr % POS_RANGE_L);
            for (int i = 0; i < BURST_LEN; i++) begin
                mask_sel[i] = lfsr[BURST_LEN-1-i];
            end
        end
    end

    assign flip    = {{(W-BURST_LEN){1'b0}}, mask_sel} << start_sel;
    assign vec_out = {checksum_i, data_i} ^ (inject ? flip : {W{1'b0}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o     <= 1'b0;
            data_o      <= '0;
            checksum_o  <= '0;
            corrupted_o <= 1'b0;
        end else if (acc) begin
            valid_o                <= 1'b1;
            {checksum_o, data_o}   <= vec_out;
            corrupted_o            <= inject && (|mask_sel);
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

`ifdef ERR_INJ_STATS_EN
    logic [31:0] inj_cnt_q;
    logic [31:0] flit_cnt_q;

    // Both counters wrap silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else begin
            if (acc) flit_cnt_q <= flit_cnt_q + 32'd1;
            if (valid_o && ready_i && corrupted_o) inj_cnt_q <= inj_cnt_q + 32'd1;
        end
    end

    assign inj_cnt_o  = inj_cnt_q;
    assign flit_cnt_o = flit_cnt_q;
`else
    assign inj_cnt_o  = 32'd0;
    assign flit_cnt_o = 32'd0;
`endif

endmodule
